regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised general-purpose register file for the pipelined CPU core. It has two combinational read ports, one write port with same-cycle write-to-read bypass, a T flag, and a per-register scoreboard that flags pending writes and raises a decode-stage stall. It also exports a flattened snapshot of all registers to the VGA debug renderer.

## Interface

Parameters:
- DATA_W, 16, register and data width
- NUM_REGS, 11, number of architectural registers: R0-R7, IH=8, SP=9, RA=10
- IDX_W, 4, index width; indices >= NUM_REGS are out of range

Ports:
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- rd_idx_s, rd_idx_m  in  IDX_W  read indices, source and modifier operands
- rd_use_s, rd_use_m  in  1  decode stage consumes that operand this cycle
- rd_data_s, rd_data_m  out  DATA_W  read data, bypassed
- wr_en  in  1  write-back valid
- wr_idx  in  IDX_W  write-back index
- wr_data  in  DATA_W  write-back data
- t_wr_en  in  1  T-flag write enable, active-high
- t_wr_data  in  1  new T value
- t_out  out  1  T flag, bypassed
- reserve_en  in  1  issuing instruction will write reserve_idx
- reserve_idx  in  IDX_W  destination being reserved
- flush  in  1  squash all in-flight producers
- stall  out  1  decode must hold
- sb_err  out  1  sticky: reserve hit an already-pending register
- regs_vga  out  NUM_REGS*DATA_W  register 0 in the MSBs, register NUM_REGS-1 in the LSBs

## Operation

- State consists of regs[NUM_REGS], pending[NUM_REGS], t, and sb_err.
- Reset (rst low, async) clears all regs, all pending bits, t, and sb_err. Outputs settle combinationally from the cleared state: rd_data and regs_vga read 0, t_out=0, stall=0, sb_err=0.
- Write: on a rising edge with wr_en=1 and wr_idx < NUM_REGS, regs[wr_idx] takes wr_data. An out-of-range wr_idx is ignored.
- Read (combinational), per port:
  - Out-of-range index returns 0.
  - If wr_en=1 and wr_idx equals the read index (in range), the port returns wr_data (bypass).
  - Otherwise the port returns regs[idx].
- T flag: updates on a rising edge when t_wr_en=1. t_out equals t_wr_data while t_wr_en=1, otherwise t.
- Scoreboard, per in-range index i, evaluated on each rising edge:
  - flush=1: pending[i] clears, unless wr_en&&wr_idx==i also holds (no effect). reserve_en is ignored.
  - else reserve_en=1 and reserve_idx==i: pending[i] sets. This wins over a same-cycle write-back to i (new producer). sb_err sets if pending[i] was already 1 and there is no same-cycle write-back to i.
  - else wr_en=1 and wr_idx==i: pending[i] clears.
  - An out-of-range reserve_idx is ignored and never sets sb_err.
- busy_x = pending[rd_idx_x] && !(wr_en && wr_idx==rd_idx_x). This is 0 for out-of-range indices.
- stall = (rd_use_s && busy_s) || (rd_use_m && busy_m). It is purely combinational.
- sb_err clears only on reset.
- regs_vga reflects committed regs only, with no bypass.

## Timing

- Read latency is 0 cycles. Bypass makes a write-back visible in the same cycle it is presented.
- Write and scoreboard latency is 1 edge. A value written at edge N is read from storage from N+ onward.
- A reserve at edge N makes stall visible from N+ until the cycle in which the matching write-back is presented (stall drops in that cycle via bypass).
- A reset assertion mid-operation clears state immediately, independent of clk. The first update after deassertion happens at the next rising edge.
- No combinational path from reserve_en or flush to any output.

## Test plan

- Reset, then write R3=0x1234 and read both ports at idx 3 -> 0x1234 next cycle; same-cycle bypass: wr R5=0xBEEF with rd_idx_s=5 -> rd_data_s=0xBEEF before the edge.
- Reserve R2, then rd_idx_m=2 with rd_use_m=1 -> stall=1 for each held cycle; present wr R2=0x0042 -> stall=0 and rd_data_m=0x0042 that cycle; pending[2]=0 afterwards.
- Simultaneous reserve R4 and write-back R4 (pending) -> regs[4] updated, pending[4] stays 1, sb_err=0; reserve R4 again with no write-back -> sb_err=1, stays 1 until reset.
- Reserve R1 and R6, then flush with reserve R7 in the same cycle -> all pending 0, R7 not reserved, stall=0 for indices 1/6/7.
- Out of range: wr_idx=12, wr_data=0xFFFF -> no register changes; rd_idx_s=15 -> 0; reserve_idx=11 -> no stall, no sb_err.
- T flag: t_wr_en=1, t_wr_data=1 -> t_out=1 same cycle and held after the edge; assert rst mid-cycle -> t_out=0, regs_vga all 0 immediately.

Source files
------------

// File: rtl/regfile_sb_if.sv
// Register-file bus between the decode/write-back stages and regfile_sb.
// Carries both read ports, the write-back port, the T flag and the scoreboard.
interface regfile_sb_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 11,
    parameter int IDX_W    = 4
);
    logic [IDX_W-1:0]           rd_idx_s;
    logic [IDX_W-1:0]           rd_idx_m;
    logic                       rd_use_s;
    logic                       rd_use_m;
    logic [DATA_W-1:0]          rd_data_s;
    logic [DATA_W-1:0]          rd_data_m;
    logic                       wr_en;
    logic [IDX_W-1:0]           wr_idx;
    logic [DATA_W-1:0]          wr_data;
    logic                       t_wr_en;
    logic                       t_wr_data;
    logic                       t_out;
    logic                       reserve_en;
    logic [IDX_W-1:0]           reserve_idx;
    logic                       flush;
    logic                       stall;
    logic                       sb_err;
    logic [NUM_REGS*DATA_W-1:0] regs_vga;

    modport master (
        output rd_idx_s, rd_idx_m, rd_use_s, rd_use_m,
        output wr_en, wr_idx, wr_data, t_wr_en, t_wr_data,
        output reserve_en, reserve_idx, flush,
        input  rd_data_s, rd_data_m, t_out, stall, sb_err, regs_vga
    );

    modport slave (
        input  rd_idx_s, rd_idx_m, rd_use_s, rd_use_m,
        input  wr_en, wr_idx, wr_data, t_wr_en, t_wr_data,
        input  reserve_en, reserve_idx, flush,
        output rd_data_s, rd_data_m, t_out, stall, sb_err, regs_vga
    );
endinterface

// File: rtl/regfile_sb.sv
// CPU register file: two bypassed read ports, one write port, T flag,
// per-register pending scoreboard with decode stall, and a VGA debug snapshot.
module regfile_sb #(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 11,
    parameter int IDX_W    = 4
) (
    input logic         clk,
    input logic         rst,
    regfile_sb_if.slave bus
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [NUM_REGS-1:0] pending;
    logic                tFlag;
    logic                sbErr;

    logic [NUM_REGS-1:0] wrHit;
    logic [NUM_REGS-1:0] resHit;
    logic [DATA_W-1:0]   rdDataS;
    logic [DATA_W-1:0]   rdDataM;
    logic                busyS;
    logic                busyM;

    // One-hot decodes; out-of-range indices match no bit, which makes them inert everywhere.
    always_comb begin
        wrHit  = '0;
        resHit = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            wrHit[i]  = bus.wr_en && (bus.wr_idx == IDX_W'(i));
            resHit[i] = bus.reserve_en && (bus.reserve_idx == IDX_W'(i));
        end
    end

    always_comb begin
        rdDataS = '0;
        rdDataM = '0;
        busyS   = 1'b0;
        busyM   = 1'b0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (bus.rd_idx_s == IDX_W'(i)) begin
                rdDataS = wrHit[i] ? bus.wr_data : regs[i];
                busyS   = pending[i] && !wrHit[i];
            end
            if (bus.rd_idx_m == IDX_W'(i)) begin
                rdDataM = wrHit[i] ? bus.wr_data : regs[i];
                busyM   = pending[i] && !wrHit[i];
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            pending <= '0;
            tFlag   <= 1'b0;
            sbErr   <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wrHit[i]) begin
                    regs[i] <= bus.wr_data;
                end
                // Flush beats reserve; a reserve beats a same-cycle write-back (new producer).
                if (bus.flush) begin
                    if (!wrHit[i]) begin
                        pending[i] <= 1'b0;
                    end
                end else if (resHit[i]) begin
                    pending[i] <= 1'b1;
                    if (pending[i] && !wrHit[i]) begin
                        sbErr <= 1'b1;
                    end
                end else if (wrHit[i]) begin
                    pending[i] <= 1'b0;
                end
            end
            if (bus.t_wr_en) begin
                tFlag <= bus.t_wr_data;
            end
        end
    end

    always_comb begin
        bus.regs_vga = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            bus.regs_vga[(NUM_REGS-1-i)*DATA_W +: DATA_W] = regs[i];
        end
    end

    assign bus.rd_data_s = rdDataS;
    assign bus.rd_data_m = rdDataM;
    assign bus.t_out     = bus.t_wr_en ? bus.t_wr_data : tFlag;
    assign bus.stall     = (bus.rd_use_s && busyS) || (bus.rd_use_m && busyM);
    assign bus.sb_err    = sbErr;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb: reads, bypass, scoreboard stall,
// sb_err stickiness, flush, out-of-range indices, T flag and async reset.
module tb_regfile_sb;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 11;
    localparam int IDX_W    = 4;
    localparam int VGA_W    = NUM_REGS * DATA_W;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    logic [DATA_W-1:0] expRegs [NUM_REGS];

    regfile_sb_if #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) bus ();

    regfile_sb #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS), .IDX_W(IDX_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [VGA_W-1:0] packExp();
        logic [VGA_W-1:0] v;
        v = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            v[(NUM_REGS-1-i)*DATA_W +: DATA_W] = expRegs[i];
        end
        return v;
    endfunction

    task automatic idle();
        bus.rd_idx_s    = '0;
        bus.rd_idx_m    = '0;
        bus.rd_use_s    = 1'b0;
        bus.rd_use_m    = 1'b0;
        bus.wr_en       = 1'b0;
        bus.wr_idx      = '0;
        bus.wr_data     = '0;
        bus.t_wr_en     = 1'b0;
        bus.t_wr_data   = 1'b0;
        bus.reserve_en  = 1'b0;
        bus.reserve_idx = '0;
        bus.flush       = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyReset();
        #2;
        rst = 1'b0;
        #3;
        rst = 1'b1;
        for (int i = 0; i < NUM_REGS; i++) expRegs[i] = '0;
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) expRegs[i] = '0;
        #2;
        checks++;
        if (bus.regs_vga !== packExp()) begin
            errors++; $display("FAIL reset_vga: got %h expected %h", bus.regs_vga, packExp());
        end
        checks++;
        if ({bus.t_out, bus.stall, bus.sb_err} !== 3'b000) begin
            errors++; $display("FAIL reset_flags: got %b expected 000", {bus.t_out, bus.stall, bus.sb_err});
        end
        checks++;
        if (bus.rd_data_s !== 16'h0000) begin
            errors++; $display("FAIL reset_rd_s: got %h expected 0000", bus.rd_data_s);
        end
        #10;
        rst = 1'b1;
        tick();
    endtask

    task automatic test_write_read();
        bus.wr_en = 1'b1; bus.wr_idx = 4'd3; bus.wr_data = 16'h1234;
        tick();
        expRegs[3] = 16'h1234;
        idle();
        bus.rd_idx_s = 4'd3; bus.rd_idx_m = 4'd3;
        #1;
        checks++;
        if (bus.rd_data_s !== 16'h1234) begin
            errors++; $display("FAIL wr_rd_s: got %h expected 1234", bus.rd_data_s);
        end
        checks++;
        if (bus.rd_data_m !== 16'h1234) begin
            errors++; $display("FAIL wr_rd_m: got %h expected 1234", bus.rd_data_m);
        end
        checks++;
        if (bus.regs_vga !== packExp()) begin
            errors++; $display("FAIL wr_vga: got %h expected %h", bus.regs_vga, packExp());
        end
    endtask

    task automatic test_bypass();
        idle();
        bus.rd_idx_s = 4'd5; bus.rd_idx_m = 4'd3;
        bus.wr_en = 1'b1; bus.wr_idx = 4'd5; bus.wr_data = 16'hBEEF;
        #1;
        checks++;
        if (bus.rd_data_s !== 16'hBEEF) begin
            errors++; $display("FAIL bypass_s: got %h expected beef", bus.rd_data_s);
        end
        checks++;
        if (bus.rd_data_m !== 16'h1234) begin
            errors++; $display("FAIL bypass_other_m: got %h expected 1234", bus.rd_data_m);
        end
        checks++;
        if (bus.regs_vga !== packExp()) begin
            errors++; $display("FAIL bypass_vga_nobypass: got %h expected %h", bus.regs_vga, packExp());
        end
        tick();
        expRegs[5] = 16'hBEEF;
        idle();
        bus.rd_idx_m = 4'd5;
        #1;
        checks++;
        if (bus.rd_data_m !== 16'hBEEF) begin
            errors++; $display("FAIL bypass_stored_m: got %h expected beef", bus.rd_data_m);
        end
    endtask

    task automatic test_stall();
        idle();
        bus.reserve_en = 1'b1; bus.reserve_idx = 4'd2;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL stall_no_comb_reserve: got %b expected 0", bus.stall);
        end
        tick();
        idle();
        bus.rd_idx_m = 4'd2; bus.rd_use_m = 1'b1;
        for (int c = 0; c < 3; c++) begin
            #1;
            checks++;
            if (bus.stall !== 1'b1) begin
                errors++; $display("FAIL stall_held%0d: got %b expected 1", c, bus.stall);
            end
            tick();
        end
        bus.rd_use_m = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL stall_unused: got %b expected 0", bus.stall);
        end
        bus.rd_use_m = 1'b1;
        bus.wr_en = 1'b1; bus.wr_idx = 4'd2; bus.wr_data = 16'h0042;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.rd_data_m !== 16'h0042) begin
            errors++; $display("FAIL stall_wb: got stall=%b data=%h expected stall=0 data=0042", bus.stall, bus.rd_data_m);
        end
        tick();
        expRegs[2] = 16'h0042;
        bus.wr_en = 1'b0;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.rd_data_m !== 16'h0042) begin
            errors++; $display("FAIL stall_cleared: got stall=%b data=%h expected stall=0 data=0042", bus.stall, bus.rd_data_m);
        end
    endtask

    task automatic test_reserve_wb();
        idle();
        bus.reserve_en = 1'b1; bus.reserve_idx = 4'd4;
        tick();
        bus.wr_en = 1'b1; bus.wr_idx = 4'd4; bus.wr_data = 16'h4444;
        tick();
        expRegs[4] = 16'h4444;
        idle();
        bus.rd_idx_s = 4'd4; bus.rd_use_s = 1'b1;
        #1;
        checks++;
        if (bus.sb_err !== 1'b0) begin
            errors++; $display("FAIL resv_wb_err: got %b expected 0", bus.sb_err);
        end
        checks++;
        if (bus.stall !== 1'b1 || bus.rd_data_s !== 16'h4444) begin
            errors++; $display("FAIL resv_wb_pending: got stall=%b data=%h expected stall=1 data=4444", bus.stall, bus.rd_data_s);
        end
        bus.reserve_en = 1'b1; bus.reserve_idx = 4'd4;
        tick();
        bus.reserve_en = 1'b0;
        #1;
        checks++;
        if (bus.sb_err !== 1'b1) begin
            errors++; $display("FAIL resv_double_err: got %b expected 1", bus.sb_err);
        end
        bus.wr_en = 1'b1; bus.wr_idx = 4'd4; bus.wr_data = 16'h4445;
        tick();
        expRegs[4] = 16'h4445;
        idle();
        tick();
        #1;
        checks++;
        if (bus.sb_err !== 1'b1) begin
            errors++; $display("FAIL resv_err_sticky: got %b expected 1", bus.sb_err);
        end
        checks++;
        if (bus.regs_vga !== packExp()) begin
            errors++; $display("FAIL resv_vga: got %h expected %h", bus.regs_vga, packExp());
        end
        applyReset();
        checks++;
        if (bus.sb_err !== 1'b0) begin
            errors++; $display("FAIL resv_err_reset: got %b expected 0", bus.sb_err);
        end
    endtask

    task automatic test_flush();
        idle();
        bus.reserve_en = 1'b1; bus.reserve_idx = 4'd1;
        tick();
        bus.reserve_idx = 4'd6;
        tick();
        bus.reserve_idx = 4'd7;
        bus.flush = 1'b1;
        tick();
        idle();
        bus.rd_use_s = 1'b1;
        bus.rd_use_m = 1'b1;
        bus.rd_idx_s = 4'd1; bus.rd_idx_m = 4'd6;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL flush_1_6: got %b expected 0", bus.stall);
        end
        bus.rd_idx_s = 4'd7;
        #1;
        checks++;
        if (bus.stall !== 1'b0) begin
            errors++; $display("FAIL flush_7: got %b expected 0", bus.stall);
        end
        bus.reserve_en = 1'b1; bus.reserve_idx = 4'd7;
        tick();
        bus.reserve_en = 1'b0;
        #1;
        checks++;
        if (bus.sb_err !== 1'b0 || bus.stall !== 1'b1) begin
            errors++; $display("FAIL flush_rereserve: got err=%b stall=%b expected err=0 stall=1", bus.sb_err, bus.stall);
        end
        bus.flush = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_out_of_range();
        idle();
        bus.wr_en = 1'b1; bus.wr_idx = 4'd12; bus.wr_data = 16'hFFFF;
        bus.rd_idx_s = 4'd12; bus.rd_idx_m = 4'd15;
        #1;
        checks++;
        if (bus.rd_data_s !== 16'h0000 || bus.rd_data_m !== 16'h0000) begin
            errors++; $display("FAIL oor_read: got s=%h m=%h expected 0000 0000", bus.rd_data_s, bus.rd_data_m);
        end
        tick();
        idle();
        #1;
        checks++;
        if (bus.regs_vga !== packExp()) begin
            errors++; $display("FAIL oor_write: got %h expected %h", bus.regs_vga, packExp());
        end
        bus.reserve_en = 1'b1; bus.reserve_idx = 4'd11;
        tick();
        tick();
        bus.reserve_en = 1'b0;
        bus.rd_idx_s = 4'd11; bus.rd_use_s = 1'b1;
        #1;
        checks++;
        if (bus.stall !== 1'b0 || bus.sb_err !== 1'b0) begin
            errors++; $display("FAIL oor_reserve: got stall=%b err=%b expected 0 0", bus.stall, bus.sb_err);
        end
        idle();
    endtask

    task automatic test_tflag();
        idle();
        bus.t_wr_en = 1'b1; bus.t_wr_data = 1'b1;
        #1;
        checks++;
        if (bus.t_out !== 1'b1) begin
            errors++; $display("FAIL t_bypass: got %b expected 1", bus.t_out);
        end
        tick();
        bus.t_wr_en = 1'b0; bus.t_wr_data = 1'b0;
        #1;
        checks++;
        if (bus.t_out !== 1'b1) begin
            errors++; $display("FAIL t_held: got %b expected 1", bus.t_out);
        end
        bus.t_wr_en = 1'b1;
        #1;
        checks++;
        if (bus.t_out !== 1'b0) begin
            errors++; $display("FAIL t_bypass_zero: got %b expected 0", bus.t_out);
        end
        bus.t_wr_en = 1'b0;
        bus.wr_en = 1'b1; bus.wr_idx = 4'd10; bus.wr_data = 16'hA5A5;
        tick();
        expRegs[10] = 16'hA5A5;
        idle();
        #1;
        checks++;
        if (bus.t_out !== 1'b1 || bus.regs_vga !== packExp()) begin
            errors++; $display("FAIL t_prereset: got t=%b vga=%h expected t=1 vga=%h", bus.t_out, bus.regs_vga, packExp());
        end
        #1;
        rst = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) expRegs[i] = '0;
        #1;
        checks++;
        if (bus.t_out !== 1'b0 || bus.regs_vga !== packExp()) begin
            errors++; $display("FAIL t_async_reset: got t=%b vga=%h expected t=0 vga=0", bus.t_out, bus.regs_vga);
        end
        #1;
        rst = 1'b1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        test_reset();
        test_write_read();
        test_bypass();
        test_stall();
        test_reserve_wb();
        test_flush();
        test_out_of_range();
        test_tflag();
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
